// File: rtl/floor_request_scheduler.sv
// Elevator call scheduler: debounced call buttons, SCAN target selection,
// arrival detection and door dwell timing.
module floor_request_scheduler #(
  parameter int NUM_FLOORS      = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up
);

  localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;

  state_t                  state, state_nxt;
  logic [NUM_FLOORS-1:0]   sync1, sync2, samp, deb, deb_nxt, press;
  logic [NUM_FLOORS-1:0]   cf_mask, req_mask, clr, pend_nxt;
  logic [TW-1:0]           tcnt;
  logic [DW-1:0]           dcnt, dcnt_nxt;
  logic [3:0]              req_nxt, up_f, dn_f;
  logic                    dir_nxt, tick, in_range, restart;
  logic                    up_found, dn_found;

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      samp  <= '0;
      deb   <= '0;
      tcnt  <= '0;
    end else begin
      sync1 <= call_btn;
      sync2 <= sync1;
      tcnt  <= tick ? '0 : tcnt + TW'(1);
      if (tick) begin
        samp <= sync2;
        deb  <= deb_nxt;
      end
    end
  end

  // level only moves when two consecutive samples agree
  assign deb_nxt = (sync2 & samp) | (deb & (sync2 | samp));
  assign press   = tick ? (deb_nxt & ~deb) : '0;

  assign in_range = ({1'b0, current_floor} < 5'(NUM_FLOORS));

  always_comb begin
    cf_mask  = '0;
    req_mask = '0;
    up_found = 1'b0;
    dn_found = 1'b0;
    up_f     = '0;
    dn_f     = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cf_mask[i]  = (current_floor == 4'(i));
      req_mask[i] = (requested_floor == 4'(i));
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (4'(i) > current_floor)) begin
        up_found = 1'b1;
        up_f     = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (4'(i) < current_floor)) begin
        dn_found = 1'b1;
        dn_f     = 4'(i);
      end
    end
  end

  assign restart = (state == DWELL) && |(press & cf_mask);

  always_comb begin
    state_nxt = state;
    req_nxt   = requested_floor;
    dir_nxt   = dir_up;
    dcnt_nxt  = dcnt;
    clr       = '0;
    unique case (state)
      IDLE: begin
        if (!in_range) begin
          req_nxt = '0;
        end else if (pending == '0) begin
          req_nxt = current_floor;
        end else if (|(pending & cf_mask)) begin
          clr       = cf_mask;
          dcnt_nxt  = '0;
          state_nxt = DWELL;
        end else begin
          state_nxt = SERVE;
          if (dir_up) begin
            if (up_found) begin
              req_nxt = up_f;
            end else begin
              req_nxt = dn_f;
              dir_nxt = 1'b0;
            end
          end else begin
            if (dn_found) begin
              req_nxt = dn_f;
            end else begin
              req_nxt = up_f;
              dir_nxt = 1'b1;
            end
          end
        end
      end
      SERVE: begin
        if (in_range && (current_floor == requested_floor)) begin
          clr       = req_mask;
          dcnt_nxt  = '0;
          state_nxt = DWELL;
        end else if (dir_up && up_found && (up_f < requested_floor)) begin
          req_nxt = up_f;
        end else if (!dir_up && dn_found && (dn_f > requested_floor)) begin
          req_nxt = dn_f;
        end
      end
      DWELL: begin
        if (restart) begin
          dcnt_nxt = '0;
        end else if (dcnt == DWELL_LAST) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a press at the floor being served is swallowed by the open door
  always_comb begin
    pend_nxt = pending | (press & ~((state == DWELL) ? cf_mask : '0));
    pend_nxt = pend_nxt & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      dcnt            <= '0;
      requested_floor <= '0;
      dir_up          <= 1'b1;
      pending         <= '0;
      door_open       <= 1'b0;
    end else begin
      state           <= state_nxt;
      dcnt            <= dcnt_nxt;
      requested_floor <= req_nxt;
      dir_up          <= dir_nxt;
      pending         <= pend_nxt;
      door_open       <= (state_nxt == DWELL);
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench for floor_request_scheduler: expectations queued at
// stimulus time, popped and compared when the DUT reaches the event.
module tb_floor_request_scheduler;

  localparam int NF = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call_btn = '0;
  logic [3:0]    current_floor = 4'd0;
  logic [3:0]    requested_floor;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          dir_up;

  floor_request_scheduler #(
    .NUM_FLOORS(NF),
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call_btn(call_btn),
    .current_floor(current_floor),
    .requested_floor(requested_floor),
    .pending(pending),
    .door_open(door_open),
    .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic wait_door(input logic lvl, input int budget);
    int n;
    n = 0;
    while (door_open !== lvl && n < budget) begin
      step(1);
      n++;
    end
    if (door_open !== lvl) check_eq("door_wait", 32'(door_open), 32'(lvl));
  endtask

  task automatic press(input int f, input int len);
    call_btn[f] = 1'b1;
    step(len);
    call_btn[f] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int   n, a, t1, exp_len;
  logic p4;

  initial begin
    step(3);
    expect_val("rst_req", 0);
    expect_val("rst_pend", 0);
    expect_val("rst_door", 0);
    expect_val("rst_dir", 1);
    pop_chk(32'(requested_floor));
    pop_chk(32'(pending));
    pop_chk(32'(door_open));
    pop_chk(32'(dir_up));
    reset = 1'b0;

    // single call from the ground floor
    expect_val("t1_pend", 32'h004);
    expect_val("t1_req", 2);
    expect_val("t1_dir", 1);
    press(2, 20);
    step(2);
    pop_chk(32'(pending));
    pop_chk(32'(requested_floor));
    pop_chk(32'(dir_up));

    current_floor = 4'd1;
    step(3);
    expect_val("t2_dwell_len", 16);
    expect_val("t2_pend", 0);
    expect_val("t2_req", 2);
    current_floor = 4'd2;
    wait_door(1'b1, 5);
    n = 0;
    while (door_open && n < 100) begin
      step(1);
      n++;
    end
    pop_chk(32'(n));
    pop_chk(32'(pending));
    step(2);
    pop_chk(32'(requested_floor));

    // two calls on either side, sweep up first
    current_floor = 4'd1;
    step(2);
    expect_val("t3_req_up", 5);
    expect_val("t3_dir_up", 1);
    call_btn[0] = 1'b1;
    call_btn[5] = 1'b1;
    step(20);
    call_btn = '0;
    step(2);
    pop_chk(32'(requested_floor));
    pop_chk(32'(dir_up));
    expect_val("t3_pend_left", 32'h001);
    current_floor = 4'd5;
    wait_door(1'b1, 5);
    pop_chk(32'(pending));
    expect_val("t3_req_dn", 0);
    expect_val("t3_dir_dn", 0);
    wait_door(1'b0, 40);
    step(2);
    pop_chk(32'(requested_floor));
    pop_chk(32'(dir_up));

    // retarget on the way up
    current_floor = 4'd3;
    do_reset();
    expect_val("t4_req7", 7);
    expect_val("t4_dir", 1);
    press(7, 20);
    step(2);
    pop_chk(32'(requested_floor));
    pop_chk(32'(dir_up));
    expect_val("t4_behind", 7);
    press(2, 20);
    step(2);
    pop_chk(32'(requested_floor));
    expect_val("t4_req5", 5);
    expect_val("t4_pend", 32'h0A4);
    press(5, 20);
    step(2);
    pop_chk(32'(requested_floor));
    pop_chk(32'(pending));

    // glitch and short pulse rejection
    current_floor = 4'd0;
    do_reset();
    step(4);
    call_btn[4] = 1'b1;
    step(1);
    call_btn[4] = 1'b0;
    step(20);
    while (cyc % 4 != 2) step(1);
    call_btn[4] = 1'b1;
    step(5);
    call_btn[4] = 1'b0;
    step(20);
    expect_val("t5_pend_glitch", 0);
    expect_val("t5_req_glitch", 0);
    pop_chk(32'(pending));
    pop_chk(32'(requested_floor));

    // press at the open floor restarts the dwell
    press(4, 20);
    step(12);
    current_floor = 4'd4;
    wait_door(1'b1, 5);
    a = cyc;
    t1 = a + 3;
    while (t1 % 4 != 0) t1++;
    exp_len = t1 + 4 - a + 16;
    expect_val("t5_dwell_restart", 32'(exp_len));
    expect_val("t5_p4_seen", 0);
    expect_val("t5_pend_after", 0);
    call_btn[4] = 1'b1;
    n = 0;
    p4 = 1'b0;
    while (door_open && n < 100) begin
      if (n == 12) call_btn[4] = 1'b0;
      step(1);
      n++;
      p4 = p4 | pending[4];
    end
    call_btn[4] = 1'b0;
    pop_chk(32'(n));
    pop_chk(32'(p4));
    pop_chk(32'(pending));

    // asynchronous reset in the middle of a dwell
    current_floor = 4'd3;
    do_reset();
    step(2);
    call_btn[3] = 1'b1;
    wait_door(1'b1, 30);
    call_btn[3] = 1'b0;
    step(3);
    expect_val("t6_pre_req", 3);
    expect_val("t6_pre_door", 1);
    pop_chk(32'(requested_floor));
    pop_chk(32'(door_open));
    expect_val("t6_rst_req", 0);
    expect_val("t6_rst_pend", 0);
    expect_val("t6_rst_door", 0);
    expect_val("t6_rst_dir", 1);
    #2 reset = 1'b1;
    #1;
    pop_chk(32'(requested_floor));
    pop_chk(32'(pending));
    pop_chk(32'(door_open));
    pop_chk(32'(dir_up));
    step(2);
    reset = 1'b0;

    // out-of-range floor keeps the FSM idle
    current_floor = 4'd12;
    step(2);
    expect_val("t6_oor_pend", 32'h040);
    expect_val("t6_oor_req", 0);
    expect_val("t6_oor_door", 0);
    press(6, 20);
    step(2);
    pop_chk(32'(pending));
    pop_chk(32'(requested_floor));
    pop_chk(32'(door_open));
    expect_val("t6_back_req", 6);
    expect_val("t6_back_dir", 1);
    current_floor = 4'd2;
    step(2);
    pop_chk(32'(requested_floor));
    pop_chk(32'(dir_up));

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_request_scheduler.md
# floor_request_scheduler

Upstream stage of the elevator controller. It debounces and latches the per-floor call buttons, picks the next target floor using a SCAN (keep-direction) policy, and drives the `requested_floor` input of the elevator state machine. It closes the loop through `current_floor`: it detects arrival at the target, clears that request and holds the door open for a dwell period.

## Interface
- `NUM_FLOORS`, default 10: number of floors. Floors are 0..NUM_FLOORS-1; the maximum is 16.
- `DEBOUNCE_CYCLES`, default 4: sampling period, in clk cycles, of the button debouncer.
- `DWELL_CYCLES`, default 16: door-open time, in clk cycles.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high.
- `call_btn` input NUM_FLOORS: raw, asynchronous, active-high buttons; bit i is floor i.
- `current_floor` input 4: floor reported by the elevator state machine.
- `requested_floor` output 4: registered target floor, driven to the elevator state machine.
- `pending` output NUM_FLOORS: latched, unserved requests.
- `door_open` output 1: high in the DWELL state.
- `dir_up` output 1: current sweep direction; 1 means up.

## Operation
- **Input sync:** each `call_btn` bit passes through a 2-flop synchronizer.
- **Debouncer:**
  - A free-running tick fires every DEBOUNCE_CYCLES cycles and samples the synchronized buttons.
  - A bit's debounced level goes to 1 after two consecutive samples of 1, and to 0 after two consecutive samples of 0.
  - A 0→1 transition of the debounced level is an accepted press, which sets `pending[i]`.
- **FSM, IDLE:**
  - If `pending` is 0, `requested_floor` takes `current_floor`.
  - If `pending[current_floor]` is set, clear it, open the door and go to DWELL. The direction is unchanged.
  - Else, if `dir_up`=1: the target is the lowest pending floor above `current_floor`. If there is none, the target is the highest pending floor below, and `dir_up` is set to 0.
  - If `dir_up`=0, the rule is mirrored (highest pending floor below first, then lowest above, setting `dir_up` to 1).
  - Load `requested_floor` with the target and go to SERVE.
- **FSM, SERVE:**
  - Retarget: if a pending floor f lies strictly between `current_floor` and `requested_floor` in the travel direction, `requested_floor` takes the nearest such f. Floors at or behind `current_floor` are never selected.
  - Arrival: when `current_floor` == `requested_floor`, clear `pending[requested_floor]`, reset the dwell counter and go to DWELL.
- **FSM, DWELL:**
  - `door_open`=1 and `requested_floor` is held.
  - The counter counts up to DWELL_CYCLES-1, then the FSM goes to IDLE.
  - An accepted press of `current_floor` during DWELL is not latched; it restarts the dwell counter.
- **Out-of-range `current_floor`** (>= NUM_FLOORS):
  - In IDLE, the FSM stays in IDLE and `requested_floor`=0.
  - In SERVE, no arrival is detected.
  - `pending` is still updated.
- **Simultaneous events:**
  - A press and a clear of the same bit in the same cycle: the clear wins. The press is dropped if the FSM is entering DWELL at that floor; otherwise it is latched on the next tick.
  - Multiple presses in one tick are all latched.
- **Widths:**
  - Floor comparisons are 4-bit unsigned.
  - The dwell counter is $clog2(DWELL_CYCLES) bits wide, minimum 1.
  - The debounce tick counter is $clog2(DEBOUNCE_CYCLES) bits wide, minimum 1.

## Timing
- **Reset values:**
  - `requested_floor`=0, `pending`=0, `door_open`=0, `dir_up`=1.
  - FSM in IDLE; synchronizers, debounced levels and counters all 0.
  - Reset mid-SERVE or mid-DWELL aborts immediately; the next cycle after release is IDLE.
- **Press to `pending` latency:** 2 sync cycles plus 1 to 2 ticks; at most 2+2·DEBOUNCE_CYCLES+1 cycles.
- **`pending` to `requested_floor`:** in IDLE, `requested_floor` is updated on the edge after `pending` becomes non-zero. SERVE is entered on the same edge.
- **Arrival:** on the edge after `current_floor` matches:
  - `door_open` rises;
  - the `pending` bit clears;
  - the state becomes DWELL.
- **Dwell length:** `door_open` is high for exactly DWELL_CYCLES cycles when no restart occurs.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. Reset, then press floor 2 for 20 cycles with `current_floor`=0 → `pending`=0x004, `requested_floor`=2, `dir_up`=1.
2. Step `current_floor` from 0 to 2 → `door_open` high for 16 cycles, `pending`=0, then IDLE with `requested_floor`=2.
3. From `current_floor`=1 and `dir_up`=1, press floors 0 and 5 together → target 5 first, then 0 after DWELL with `dir_up`=0.
4. In SERVE toward floor 7 at `current_floor`=3, press floor 5 → `requested_floor` becomes 5. Pressing floor 2 does not retarget.
5. A 1-cycle glitch and a 5-cycle pulse on `call_btn[4]` → `pending[4]` stays 0. Pressing floor 4 while in DWELL at floor 4 → dwell restarts and `pending[4]` stays 0.
6. Assert `reset` mid-DWELL → all outputs return to reset values asynchronously. `current_floor`=12 with a pending request → `requested_floor`=0 and the FSM stays in IDLE.
